rr_arbiter4: RTL
================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one requester may hold a grant (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared resource; held high for the whole ownership.
REQ-005 SHALL have port gnt, output, 4 bits, registered: one-hot grant, or all-zero when there is no owner.
REQ-006 SHALL have port gnt_idx, output, 2 bits, registered: binary index of the set gnt bit; 2'b00 when gnt is zero.
REQ-007 SHALL have port gnt_valid, output, 1 bit, registered: high if and only if gnt is non-zero.
REQ-008 SHALL have port timeout, output, 1 bit, registered: one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-010 IDLE, req == 0: SHALL stay in IDLE with gnt = 0.
REQ-011 IDLE, req != 0: SHALL pick the first set req bit scanning upward from ptr, wrapping 3 -> 0.
REQ-012 On a pick, SHALL assert gnt, gnt_idx and gnt_valid on the next clock edge (latency 1 cycle from req to gnt), and move to BUSY.
REQ-013 On a pick, SHALL set ptr to winner+1 modulo 4 (2-bit wrap), so the winner has the lowest priority next time.
REQ-014 BUSY, req[owner] still high and hold count < MAX_HOLD: SHALL keep gnt unchanged.
REQ-015 Other req bits SHALL have no effect while in BUSY.
REQ-016 BUSY, req[owner] low: SHALL clear gnt, gnt_idx and gnt_valid on the next edge and return to IDLE.
REQ-017 After every ownership ends, SHALL hold gnt = 0 for exactly one cycle (turnaround) before any new grant.
REQ-018 The hold counter SHALL be loaded with 1 on the grant edge and increment by 1 on each edge in BUSY.
REQ-019 When the hold count equals MAX_HOLD and req[owner] is still high, SHALL clear gnt on the next edge, pulse timeout high for that one cycle, and return to IDLE.
REQ-020 A revoked requester SHALL be re-granted only through normal round-robin order.
REQ-021 If req[owner] falls on the same edge as the MAX_HOLD limit, SHALL treat it as a normal release: timeout stays low.
REQ-022 The hold counter SHALL be wide enough for MAX_HOLD and SHALL never wrap.
REQ-023 gnt SHALL never have more than one bit set in any cycle.
REQ-024 gnt_idx SHALL always equal the encoded value of gnt.

Reset
REQ-025 rst_n low SHALL at once (asynchronously) force: state = IDLE, gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0, ptr = 0, hold count = 0.
REQ-026 Reset asserted during BUSY SHALL drop the grant at once, with no timeout pulse.
REQ-027 After rst_n rises, the first arbitration SHALL give priority to req[0].

Structure
REQ-028 A shared package rr_arb_pkg SHALL hold the FSM state typedef (IDLE, BUSY), NUM_REQ = 4 and IDX_W = 2.
REQ-029 A sub-module grant_encoder SHALL convert the combinational one-hot winner to a 2-bit index; gnt_idx is then registered in rr_arbiter4.

Verification
REQ-030 Reset, then req = 4'b0001 for 3 cycles, then 0: gnt = 0001 and gnt_idx = 00 exactly one cycle after req rises; gnt = 0 one cycle after req falls.
REQ-031 req = 4'b1111 held, each owner dropping its req after 2 cycles of grant and re-raising it on the next cycle: grant order 0,1,2,3,0; exactly one gnt-zero cycle between owners.
REQ-032 MAX_HOLD = 4, req = 4'b0100 held constant: gnt = 0100 for 4 cycles; then gnt = 0 with timeout = 1 for one cycle; then gnt = 0100 again.
REQ-033 MAX_HOLD = 4, req[2] drops on the same edge the hold count reaches 4: gnt clears and timeout stays 0.
REQ-034 rst_n pulsed low mid-BUSY with owner 3: gnt = 0 at once, no timeout pulse; after release with req = 4'b1001, the grant goes to requester 0.
REQ-035 Every cycle of every test: gnt has at most one bit set, gnt_valid equals (gnt != 0), and gnt_idx matches gnt.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   NUM_REQ     : number of requesters
//   IDX_W       : width of a binary requester index
//   arb_state_e : arbiter FSM state (IDLE = no owner, BUSY = one owner)
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/grant_encoder.sv
// One-hot to binary encoder for the arbitration winner.
//   onehot_i : one-hot (or all-zero) winner vector
//   idx_o    : binary index of the set bit, 0 when onehot_i is zero
module grant_encoder
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] onehot_i,
    output logic [IDX_W-1:0]   idx_o
);

    // OR-ing the indices of set bits is exact for a one-hot input and
    // yields 0 for an all-zero input.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a maximum-hold limit.
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   req       : request vector, held high by the owner for the whole ownership
//   gnt       : registered one-hot grant (all-zero when there is no owner)
//   gnt_idx   : registered binary index of the granted requester
//   gnt_valid : registered, high when gnt is non-zero
//   timeout   : registered one-cycle pulse when a grant is revoked at MAX_HOLD
// A grant lasts while the owner keeps its request high, up to MAX_HOLD
// cycles. Every ownership is followed by one idle turnaround cycle.
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    // Sized so that MAX_HOLD itself is representable; the counter stops at
    // MAX_HOLD, so it can never wrap.
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [NUM_REQ-1:0]  winner_oh;
    logic [IDX_W-1:0]    winner_idx;
    logic                winner_found;
    logic [IDX_W-1:0]    cand;
    logic                owner_req;

    // Scan upward from ptr, wrapping 3 -> 0 through the 2-bit addition.
    always_comb begin
        winner_oh    = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!winner_found && req[cand]) begin
                winner_oh[cand] = 1'b1;
                winner_found    = 1'b1;
            end
        end
    end

    grant_encoder u_grant_encoder (
        .onehot_i (winner_oh),
        .idx_o    (winner_idx)
    );

    // gnt_idx_q names the owner whenever the FSM is BUSY.
    assign owner_req = req[gnt_idx_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    gnt_d     = winner_oh;
                    gnt_idx_d = winner_idx;
                    // Winner drops to lowest priority for the next pick.
                    ptr_d     = winner_idx + IDX_W'(1);
                    hold_d    = HOLD_W'(1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (!owner_req || (hold_q == HOLD_MAX)) begin
                    // A release on the limit edge is a normal release.
                    timeout_d = owner_req;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    hold_d    = '0;
                    state_d   = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                gnt_d     = '0;
                gnt_idx_d = '0;
                hold_d    = '0;
                state_d   = IDLE;
            end
        endcase

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
